// File: rtl/f2h_event_reporter.sv
// f2h_event_reporter: host-bound half of the MMIO link.
// Captures completion events (move done, load/store done, control unit finished), timestamps
// them, queues them in a small FIFO and sends one 32-bit event word at a time to the host. The
// host must acknowledge each word. An unacknowledged word is sent again on timeout and dropped
// after MaxRetry retransmissions.
// Ports:
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   enable_i       event capture enable
//   move_done_i    level; a rising edge raises event code 1
//   ldst_done_i    level; a rising edge raises event code 2
//   cu_running_i   level; a falling edge raises event code 3
//   h2f_pio32_i    host write data; acks use opcode AckCode in [31:28] and the seq in [27:24]
//   h2f_write_i    host write strobe
//   f2h_pio32_o    event word {code[3:0], seq[3:0], timestamp[23:0]}
//   f2h_write_o    one-cycle strobe for each (re)transmission
//   busy_o         transmitter active or FIFO non-empty
//   overflow_o     sticky; an event was lost
//   drop_cnt_o     saturating count of words dropped after retries
module f2h_event_reporter #(
   parameter int unsigned FifoDepth = 8,
   parameter int unsigned Timeout   = 1024,
   parameter int unsigned MaxRetry  = 3,
   parameter logic [3:0]  AckCode   = 4'hE
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        move_done_i,
   input  logic        ldst_done_i,
   input  logic        cu_running_i,
   input  logic [31:0] h2f_pio32_i,
   input  logic        h2f_write_i,
   output logic [31:0] f2h_pio32_o,
   output logic        f2h_write_o,
   output logic        busy_o,
   output logic        overflow_o,
   output logic [7:0]  drop_cnt_o
);

   // The word format fixes the timestamp at 24 bits.
   localparam int unsigned TsW  = 24;
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned TmoW = $clog2(Timeout);
   localparam int unsigned RtyW = $clog2(MaxRetry + 2);

   localparam logic [3:0] CodeMove = 4'h1;
   localparam logic [3:0] CodeLdst = 4'h2;
   localparam logic [3:0] CodeCu   = 4'h3;
   localparam logic [3:0] CodeOvf  = 4'hF;

   typedef enum logic [1:0] {StIdle, StSend, StWaitAck} state_e;

   state_e            state_q, state_d;
   logic [TsW-1:0]    ts_q;
   logic [3:0]        seq_q;
   logic              prev_move_q, prev_ldst_q, prev_cu_q;
   logic [2:0]        pend_q, pend_d;
   logic [TsW-1:0]    pend_ts_q [3];
   logic [TsW-1:0]    pend_ts_d [3];
   logic              pend_f_q, pend_f_d;
   logic [TsW-1:0]    pend_f_ts_q, pend_f_ts_d;
   logic              overflow_q, overflow_d;
   logic [31:0]       mem_q [FifoDepth];
   logic [PtrW:0]     wptr_q, rptr_q;
   logic [31:0]       out_q, out_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [RtyW-1:0]   retry_q, retry_d;
   logic [7:0]        drop_q, drop_d;

   logic [2:0]  ev, clr, lost;
   logic        clr_f, push, pop, fifo_full, fifo_empty, ack;
   logic [31:0] push_word;
   logic        unused_h2f;

   assign unused_h2f = ^h2f_pio32_i[23:0];

   assign ev[0] = enable_i & move_done_i & ~prev_move_q;
   assign ev[1] = enable_i & ldst_done_i & ~prev_ldst_q;
   assign ev[2] = enable_i & ~cu_running_i & prev_cu_q;

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                       (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

   // Fixed-priority push arbiter: code 1 > code 2 > code 3 > code F.
   always_comb begin
      push      = 1'b0;
      clr       = '0;
      clr_f     = 1'b0;
      push_word = '0;
      if (!fifo_full) begin
         if (pend_q[0]) begin
            push      = 1'b1;
            clr[0]    = 1'b1;
            push_word = {CodeMove, seq_q, pend_ts_q[0]};
         end else if (pend_q[1]) begin
            push      = 1'b1;
            clr[1]    = 1'b1;
            push_word = {CodeLdst, seq_q, pend_ts_q[1]};
         end else if (pend_q[2]) begin
            push      = 1'b1;
            clr[2]    = 1'b1;
            push_word = {CodeCu, seq_q, pend_ts_q[2]};
         end else if (pend_f_q) begin
            push      = 1'b1;
            clr_f     = 1'b1;
            push_word = {CodeOvf, seq_q, pend_f_ts_q};
         end
      end
   end

   // A flag cleared by this cycle's push may be re-set by a same-cycle edge without loss.
   always_comb begin
      pend_d = '0;
      lost   = '0;
      for (int i = 0; i < 3; i++) begin
         pend_ts_d[i] = pend_ts_q[i];
         lost[i]      = ev[i] & pend_q[i] & ~clr[i];
         pend_d[i]    = (pend_q[i] & ~clr[i]) | ev[i];
         if (ev[i] && !(pend_q[i] && !clr[i])) begin
            pend_ts_d[i] = ts_q;
         end
      end
      // The overflow notice is one-shot: it keeps the first lost timestamp until pushed.
      pend_f_d    = (pend_f_q & ~clr_f) | (|lost);
      pend_f_ts_d = pend_f_ts_q;
      if ((|lost) && !(pend_f_q && !clr_f)) begin
         pend_f_ts_d = ts_q;
      end
      overflow_d = overflow_q | (|lost);
   end

   // Transmit FSM.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      tmo_d       = tmo_q;
      retry_d     = retry_q;
      drop_d      = drop_q;
      pop         = 1'b0;
      f2h_write_o = 1'b0;
      ack = h2f_write_i && (h2f_pio32_i[31:28] == AckCode) &&
            (h2f_pio32_i[27:24] == out_q[27:24]);
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               out_d   = mem_q[rptr_q[PtrW-1:0]];
               retry_d = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            f2h_write_o = 1'b1;
            tmo_d       = '0;
            state_d     = StWaitAck;
         end
         StWaitAck: begin
            if (ack) begin
               state_d = StIdle;
            end else if (tmo_q == TmoW'(Timeout - 1)) begin
               if (retry_q < RtyW'(MaxRetry)) begin
                  retry_d = retry_q + RtyW'(1);
                  state_d = StSend;
               end else begin
                  if (drop_q != 8'hFF) begin
                     drop_d = drop_q + 8'd1;
                  end
                  state_d = StIdle;
               end
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         ts_q        <= '0;
         seq_q       <= '0;
         prev_move_q <= 1'b0;
         prev_ldst_q <= 1'b0;
         prev_cu_q   <= 1'b0;
         pend_q      <= '0;
         for (int i = 0; i < 3; i++) begin
            pend_ts_q[i] <= '0;
         end
         pend_f_q    <= 1'b0;
         pend_f_ts_q <= '0;
         overflow_q  <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         out_q       <= '0;
         tmo_q       <= '0;
         retry_q     <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         ts_q        <= ts_q + TsW'(1);
         prev_move_q <= move_done_i;
         prev_ldst_q <= ldst_done_i;
         prev_cu_q   <= cu_running_i;
         pend_q      <= pend_d;
         for (int i = 0; i < 3; i++) begin
            pend_ts_q[i] <= pend_ts_d[i];
         end
         pend_f_q    <= pend_f_d;
         pend_f_ts_q <= pend_f_ts_d;
         overflow_q  <= overflow_d;
         out_q       <= out_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         drop_q      <= drop_d;
         if (push) begin
            wptr_q <= wptr_q + (PtrW + 1)'(1);
            seq_q  <= seq_q + 4'd1;
         end
         if (pop) begin
            rptr_q <= rptr_q + (PtrW + 1)'(1);
         end
      end
   end

   // FIFO storage needs no reset; the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q[PtrW-1:0]] <= push_word;
      end
   end

   assign f2h_pio32_o = out_q;
   assign busy_o      = (state_q != StIdle) || !fifo_empty;
   assign overflow_o  = overflow_q;
   assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_f2h_event_reporter.sv
// Directed bench for f2h_event_reporter. Expected event words are queued when an edge is driven
// and compared when the DUT strobes f2h_write.
module tb_f2h_event_reporter;

   logic        clk = 1'b0;
   logic        rst_n, enable, move_done, ldst_done, cu_running, h2f_write;
   logic [31:0] h2f_pio32, f2h_pio32;
   logic        f2h_write, busy, overflow;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   f2h_event_reporter dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (enable),
      .move_done_i  (move_done),
      .ldst_done_i  (ldst_done),
      .cu_running_i (cu_running),
      .h2f_pio32_i  (h2f_pio32),
      .h2f_write_i  (h2f_write),
      .f2h_pio32_o  (f2h_pio32),
      .f2h_write_o  (f2h_write),
      .busy_o       (busy),
      .overflow_o   (overflow),
      .drop_cnt_o   (drop_cnt)
   );

   // Reference timestamp and cycle counter.
   logic [23:0] m_ts;
   logic        ts_set;
   logic [23:0] ts_set_val;
   int unsigned cyc_now;
   always @(posedge clk) begin
      cyc_now <= cyc_now + 1;
      if (!rst_n)      m_ts <= '0;
      else if (ts_set) m_ts <= ts_set_val;
      else             m_ts <= m_ts + 24'd1;
   end

   logic [31:0] exp_q [$];
   logic [3:0]  exp_seq;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] last_w;
   int unsigned last_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_push(input logic [3:0] code, input logic [23:0] ts);
      exp_q.push_back({code, exp_seq, ts});
      exp_seq = exp_seq + 4'd1;
   endtask

   task automatic wait_tx(output logic [31:0] w, output int unsigned t, output bit ok);
      ok = 1'b0;
      w  = '0;
      t  = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (f2h_write) begin
            ok = 1'b1;
            w  = f2h_pio32;
            t  = cyc_now;
         end
      end
   endtask

   task automatic expect_tx(input string tag);
      logic [31:0] w, e;
      int unsigned t;
      bit          ok;
      wait_tx(w, t, ok);
      e = 32'hDEAD_BEEF;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check({tag, "_present"}, 32'(ok), 32'd1);
      check(tag, w, e);
      last_w = w;
      last_t = t;
   endtask

   task automatic send_h2f(input logic [31:0] d);
      tick();
      h2f_write = 1'b1;
      h2f_pio32 = d;
      tick();
      h2f_write = 1'b0;
      h2f_pio32 = '0;
   endtask

   task automatic ack(input logic [3:0] s);
      send_h2f({4'hE, s, 24'h0});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w, w0, exp_w;
      int unsigned t, t0, tprev;
      bit          ok;
      int          cnt;
      logic [23:0] ts10, ts11;

      rst_n = 1'b0; enable = 1'b0; move_done = 1'b0; ldst_done = 1'b0; cu_running = 1'b0;
      h2f_pio32 = '0; h2f_write = 1'b0; ts_set = 1'b0; ts_set_val = '0; exp_seq = '0;
      ts10 = '0; ts11 = '0;
      tick();
      tick();
      @(negedge clk);
      check("rst_pio", f2h_pio32, 32'd0);
      check("rst_write", 32'(f2h_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;

      // Capture and latency: move_done rises at timestamp 0x10.
      while (m_ts != 24'h10) tick();
      move_done = 1'b1;
      t0 = cyc_now;
      expect_push(4'h1, m_ts);
      expect_tx("t1_word");
      check("t1_word_literal", last_w, 32'h1000_0010);
      check("t1_latency", last_t - t0, 32'd3);
      ack(last_w[27:24]);
      @(negedge clk);
      check("t1_busy_after_ack", 32'(busy), 32'd0);

      // Simultaneous edges on all three sources.
      tick();
      move_done = 1'b0;
      cu_running = 1'b1;
      tick();
      tick();
      move_done = 1'b1;
      ldst_done = 1'b1;
      cu_running = 1'b0;
      expect_push(4'h1, m_ts);
      expect_push(4'h2, m_ts);
      expect_push(4'h3, m_ts);
      for (int i = 0; i < 3; i++) begin
         expect_tx("t2_word");
         ack(last_w[27:24]);
      end

      // Wrong acks are ignored; the word is retransmitted after the timeout.
      tick();
      move_done = 1'b0;
      tick();
      move_done = 1'b1;
      expect_push(4'h1, m_ts);
      expect_tx("t3_first");
      w0 = last_w;
      t0 = last_t;
      send_h2f({4'hE, w0[27:24] + 4'd1, 24'h0});
      send_h2f({4'h1, w0[27:24], 24'h0});
      wait_tx(w, t, ok);
      check("t3_retx_present", 32'(ok), 32'd1);
      check("t3_retx_word", w, w0);
      check("t3_retx_spacing", t - t0, 32'd1025);
      ack(w0[27:24]);

      // No ack: one transmission plus three retransmissions, then drop.
      tick();
      move_done = 1'b0;
      tick();
      move_done = 1'b1;
      expect_push(4'h1, m_ts);
      expect_tx("t3_noack_first");
      w0 = last_w;
      tprev = last_t;
      tick();
      ldst_done = 1'b0;
      tick();
      ldst_done = 1'b1;
      expect_push(4'h2, m_ts);
      for (int r = 0; r < 3; r++) begin
         wait_tx(w, t, ok);
         check("t3_noack_retx_present", 32'(ok), 32'd1);
         check("t3_noack_retx_word", w, w0);
         check("t3_noack_retx_spacing", t - tprev, 32'd1025);
         tprev = t;
      end
      expect_tx("t3_after_drop");
      check("t3_after_drop_spacing", last_t - tprev, 32'd1026);
      check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
      ack(last_w[27:24]);

      // Overflow: twelve move pulses four cycles apart with acks held off.
      tick();
      move_done = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 12; i++) begin
         move_done = 1'b1;
         if (i == 10) ts10 = m_ts;
         if (i == 11) ts11 = m_ts;
         if (i <= 9) expect_push(4'h1, m_ts);
         tick();
         move_done = 1'b0;
         tick();
         tick();
         if (i == 0) begin
            @(negedge clk);
            check("t4_first_write", 32'(f2h_write), 32'd1);
            exp_w = exp_q.pop_front();
            check("t4_first_word", f2h_pio32, exp_w);
            last_w = f2h_pio32;
         end
         if (i == 9) check("t4_overflow_before_loss", 32'(overflow), 32'd0);
         tick();
      end
      check("t4_overflow_set", 32'(overflow), 32'd1);
      check("t4_busy", 32'(busy), 32'd1);
      ack(last_w[27:24]);
      for (int k = 0; k < 9; k++) begin
         expect_tx("t4_move_word");
         ack(last_w[27:24]);
      end
      wait_tx(w, t, ok);
      check("t4_ovf_present", 32'(ok), 32'd1);
      check("t4_ovf_code_seq", 32'(w[31:24]), 32'({4'hF, exp_seq}));
      check("t4_ovf_ts", 32'((w[23:0] == ts10) || (w[23:0] == ts11)), 32'd1);
      exp_seq = exp_seq + 4'd1;
      ack(w[27:24]);
      @(negedge clk);
      check("t4_busy_drained", 32'(busy), 32'd0);
      check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset while waiting for an ack.
      ldst_done = 1'b0;
      tick();
      move_done = 1'b1;
      expect_push(4'h1, m_ts);
      expect_tx("t5_word");
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      move_done = 1'b0;
      @(negedge clk);
      check("t5_rst_pio", f2h_pio32, 32'd0);
      check("t5_rst_write", 32'(f2h_write), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_overflow", 32'(overflow), 32'd0);
      check("t5_rst_drop", 32'(drop_cnt), 32'd0);
      exp_seq = '0;
      exp_q.delete();
      tick();
      move_done = 1'b1;
      expect_push(4'h1, m_ts);
      expect_tx("t5_after_reset");
      ack(last_w[27:24]);

      // Enable low: edges are not captured.
      enable = 1'b0;
      tick();
      move_done = 1'b0;
      cu_running = 1'b1;
      tick();
      move_done = 1'b1;
      ldst_done = 1'b1;
      cu_running = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (f2h_write) cnt++;
      end
      check("t6_disabled_words", 32'(cnt), 32'd0);
      check("t6_disabled_busy", 32'(busy), 32'd0);
      tick();
      enable = 1'b1;

      // Timestamp wrap: events at 0xFFFFFF and 0x000002.
      move_done = 1'b0;
      ldst_done = 1'b0;
      tick();
      ts_set = 1'b1;
      ts_set_val = 24'hFFFFFD;
      force dut.ts_q = 24'hFFFFFC;
      release dut.ts_q;
      tick();
      ts_set = 1'b0;
      while (m_ts != 24'hFFFFFF) tick();
      move_done = 1'b1;
      expect_push(4'h1, m_ts);
      while (m_ts != 24'h000002) tick();
      ldst_done = 1'b1;
      expect_push(4'h2, m_ts);
      expect_tx("t7_ts_ffffff");
      ack(last_w[27:24]);
      expect_tx("t7_ts_000002");
      ack(last_w[27:24]);

      // Sequence counter wraps 15 -> 0.
      for (int i = 0; i < 16; i++) begin
         tick();
         move_done = 1'b0;
         tick();
         move_done = 1'b1;
         expect_push(4'h1, m_ts);
         expect_tx("t8_seq_word");
         ack(last_w[27:24]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
